// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM states,
// master index constants and the RAM read latency.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Cycles from a granted read to valid data on ram_dout.
    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters / RAM and the arbiter.
// Handshake: a master holds mN_req (with we/lock/addr/wdata stable) until
// mN_gnt is seen high in the same cycle; the access is issued to the RAM in
// that cycle. For a read, mN_rvalid pulses exactly RAM_RD_LAT cycles later
// with mN_rdata valid; mN_rdata then holds until the next mN read completes.
// The "master" modport is the masters-plus-RAM side, "slave" is the arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
);
    logic                 m0_req;
    logic                 m0_we;
    logic                 m0_lock;
    logic [ADDR_BITS-1:0] m0_addr;
    logic [DATA_BITS-1:0] m0_wdata;
    logic                 m0_gnt;
    logic                 m0_rvalid;
    logic [DATA_BITS-1:0] m0_rdata;

    logic                 m1_req;
    logic                 m1_we;
    logic                 m1_lock;
    logic [ADDR_BITS-1:0] m1_addr;
    logic [DATA_BITS-1:0] m1_wdata;
    logic                 m1_gnt;
    logic                 m1_rvalid;
    logic [DATA_BITS-1:0] m1_rdata;

    logic                 ram_ena;
    logic                 ram_wea;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0] ram_din;
    logic [DATA_BITS-1:0] ram_dout;

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_ena, ram_wea, ram_addr, ram_din,
        output ram_dout
    );

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_ena, ram_wea, ram_addr, ram_din,
        input  ram_dout
    );

endinterface

// File: rtl/ram_rd_tracker.sv
// Per-master read return path: delays the "read issued" flag by the RAM
// latency, pulses rvalid, and holds the last returned read data.
module ram_rd_tracker
    import ram_arb_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_issue,
    input  logic [DATA_BITS-1:0] i_ram_dout,
    output logic                 o_rvalid,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [RAM_RD_LAT-1:0] r_pipe;
    logic [DATA_BITS-1:0]  r_hold;
    logic                  w_done;

    assign w_done = r_pipe[RAM_RD_LAT-1];

    // Shift the issued-read flag until the RAM data is available.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | RAM_RD_LAT'(i_rd_issue);
        end
    end

    // Capture the returned data so it stays stable after the rvalid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_done) begin
            r_hold <= i_ram_dout;
        end
    end

    assign o_rvalid = w_done;
    // In the completion cycle the RAM output is passed straight through.
    assign o_rdata  = w_done ? i_ram_dout : r_hold;

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Per-cycle round-robin arbitration in IDLE, lockable grants for
// read-modify-write, and per-master read return tracking.
// Build option RAM_ARB_FIXED_PRIO_EN: master 0 always wins an IDLE tie and
// the round-robin pointer is removed.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus,
    output state_t        o_state
);

    state_t               r_state;
    state_t               w_next;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_wea;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_din;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                 r_last;

    // Remember the last granted master; reset favours master 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= M1;
        end else if (w_gnt0) begin
            r_last <= M0;
        end else if (w_gnt1) begin
            r_last <= M1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant selection and next-state; grants are suppressed while in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    w_gnt0 = 1'b1;
`else
                    if (r_last == M0) begin
                        w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = 1'b1;
                    end
`endif
                end else if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                end else if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 && bus.m0_lock) begin
                    w_next = LOCK0;
                end else if (w_gnt1 && bus.m1_lock) begin
                    w_next = LOCK1;
                end
            end
            LOCK0: begin
                // The other master is stalled; the lock ends with an unlocked
                // access or when master 0 stops requesting.
                if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                    if (!bus.m0_lock) begin
                        w_next = IDLE;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            LOCK1: begin
                if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                    if (!bus.m1_lock) begin
                        w_next = IDLE;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // RAM command mux; idle bus is driven to zero.
    always_comb begin
        w_wea  = 1'b0;
        w_addr = '0;
        w_din  = '0;
        if (w_gnt0) begin
            w_wea  = bus.m0_we;
            w_addr = bus.m0_addr;
            w_din  = bus.m0_wdata;
        end else if (w_gnt1) begin
            w_wea  = bus.m1_we;
            w_addr = bus.m1_addr;
            w_din  = bus.m1_wdata;
        end
    end

    assign bus.m0_gnt   = w_gnt0;
    assign bus.m1_gnt   = w_gnt1;
    assign bus.ram_ena  = w_gnt0 | w_gnt1;
    assign bus.ram_wea  = w_wea;
    assign bus.ram_addr = w_addr;
    assign bus.ram_din  = w_din;
    assign o_state      = r_state;

    ram_rd_tracker #(.DATA_BITS(DATA_BITS)) u_trk0 (
        .clk        (clk),
        .rst        (rst),
        .i_rd_issue (w_gnt0 & ~bus.m0_we),
        .i_ram_dout (bus.ram_dout),
        .o_rvalid   (bus.m0_rvalid),
        .o_rdata    (bus.m0_rdata)
    );

    ram_rd_tracker #(.DATA_BITS(DATA_BITS)) u_trk1 (
        .clk        (clk),
        .rst        (rst),
        .i_rd_issue (w_gnt1 & ~bus.m1_we),
        .i_ram_dout (bus.ram_dout),
        .o_rvalid   (bus.m1_rvalid),
        .o_rdata    (bus.m1_rdata)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks;
    int     failures;

    logic [7:0] mem [0:1023];

    ram_arbiter_if #(.ADDR_BITS(10), .DATA_BITS(8)) bus ();

    ram_arbiter #(.ADDR_BITS(10), .DATA_BITS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-first, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wea) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h005] = 8'hA5;
        mem[10'h010] = 8'h11;
        mem[10'h020] = 8'h5A;
        mem[10'h021] = 8'hC3;
        mem[10'h030] = 8'h99;
        bus.ram_dout = 8'h00;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_lock = 1'b0;
        bus.m0_addr = '0;  bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0;
        bus.m1_addr = '0;  bus.m1_wdata = '0;

        // Reset: grants gated even with a pending request.
        rst = 1'b1;
        bus.m0_req = 1'b1;
        tick();
        tick();
        check("rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
        check("rst_ram_ena",   32'(bus.ram_ena),   32'd0);
        check("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        check("rst_m0_rdata",  32'(bus.m0_rdata),  32'd0);
        check("rst_m1_rdata",  32'(bus.m1_rdata),  32'd0);
        check("rst_state",     32'(dbg_state),     32'(IDLE));

        // Single m0 read of 0x005.
        rst = 1'b0;
        bus.m0_addr = 10'h005;
        #1;
        check("rd_m0_gnt",   32'(bus.m0_gnt),   32'd1);
        check("rd_m1_gnt",   32'(bus.m1_gnt),   32'd0);
        check("rd_ram_ena",  32'(bus.ram_ena),  32'd1);
        check("rd_ram_wea",  32'(bus.ram_wea),  32'd0);
        check("rd_ram_addr", 32'(bus.ram_addr), 32'h005);
        tick();
        bus.m0_req = 1'b0;
        #1;
        check("rd_rvalid",  32'(bus.m0_rvalid), 32'd1);
        check("rd_rdata",   32'(bus.m0_rdata),  32'hA5);
        check("idle_addr",  32'(bus.ram_addr),  32'h000);
        tick();
        check("rd_rvalid_pulse", 32'(bus.m0_rvalid), 32'd0);
        tick();
        check("rd_rdata_hold", 32'(bus.m0_rdata), 32'hA5);

        // Fresh reset, then both masters request continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.m0_req = 1'b1; bus.m0_addr = 10'h020;
        bus.m1_req = 1'b1; bus.m1_addr = 10'h021;
        for (int c = 0; c < 4; c++) begin
            #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            check("tie_m0_gnt", 32'(bus.m0_gnt), 32'd1);
            check("tie_m1_gnt", 32'(bus.m1_gnt), 32'd0);
`else
            check("rr_m0_gnt", 32'(bus.m0_gnt), 32'((c % 2) == 0));
            check("rr_m1_gnt", 32'(bus.m1_gnt), 32'((c % 2) == 1));
`endif
            tick();
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        check("tie_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
        check("tie_m1_rdata",  32'(bus.m1_rdata),  32'h00);
`else
        check("rr_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        check("rr_m1_rdata",  32'(bus.m1_rdata),  32'hC3);
`endif
        check("tie_m0_rdata", 32'(bus.m0_rdata), 32'h5A);

        // m0 locked RMW on 0x010 while m1 keeps requesting.
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h010;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 10'h030;
        #1;
        check("rmw_rd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
        check("rmw_rd_m1_gnt", 32'(bus.m1_gnt), 32'd0);
        tick();
        bus.m0_we = 1'b1; bus.m0_lock = 1'b0; bus.m0_wdata = 8'h3C;
        #1;
        check("rmw_state_lock", 32'(dbg_state),     32'(LOCK0));
        check("rmw_rd_data",    32'(bus.m0_rdata),  32'h11);
        check("rmw_wr_m0_gnt",  32'(bus.m0_gnt),    32'd1);
        check("rmw_wr_m1_gnt",  32'(bus.m1_gnt),    32'd0);
        check("rmw_wr_wea",     32'(bus.ram_wea),   32'd1);
        check("rmw_wr_din",     32'(bus.ram_din),   32'h3C);
        tick();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0;
        #1;
        check("rmw_state_idle", 32'(dbg_state),     32'(IDLE));
        check("rmw_m0_rvalid",  32'(bus.m0_rvalid), 32'd0);
        check("rmw_m1_gnt",     32'(bus.m1_gnt),    32'd1);
        check("rmw_mem",        32'(mem[10'h010]),  32'h3C);
        tick();
        bus.m1_req = 1'b0;
        #1;
        check("rmw_m1_rdata",   32'(bus.m1_rdata),  32'h99);
        check("rmw_m0_rdata",   32'(bus.m0_rdata),  32'h11);

        // m1 writes 0x77 to 0x3FF then reads it back.
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'h3FF; bus.m1_wdata = 8'h77;
        #1;
        check("wr_m1_gnt",   32'(bus.m1_gnt),   32'd1);
        check("wr_ram_addr", 32'(bus.ram_addr), 32'h3FF);
        check("wr_ram_wea",  32'(bus.ram_wea),  32'd1);
        tick();
        bus.m1_we = 1'b0;
        #1;
        check("wr_no_rvalid", 32'(bus.m1_rvalid), 32'd0);
        check("wr_rdata_keep", 32'(bus.m1_rdata), 32'h99);
        tick();
        bus.m1_req = 1'b0;
        #1;
        check("wr_rd_rvalid", 32'(bus.m1_rvalid), 32'd1);
        check("wr_rd_rdata",  32'(bus.m1_rdata),  32'h77);
        check("wr_m0_rdata",  32'(bus.m0_rdata),  32'h11);

        // Reset while in LOCK0 with an m0 read in flight.
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h005;
        #1;
        check("lk_m0_gnt", 32'(bus.m0_gnt), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("lk_state",    32'(dbg_state),   32'(LOCK0));
        check("lk_rst_gnt",  32'(bus.m0_gnt),  32'd0);
        check("lk_rst_ena",  32'(bus.ram_ena), 32'd0);
        tick();
        rst = 1'b0;
        bus.m0_req = 1'b0; bus.m0_lock = 1'b0;
        bus.m1_req = 1'b1; bus.m1_addr = 10'h3FF;
        #1;
        check("lk_post_state",  32'(dbg_state),     32'(IDLE));
        check("lk_post_rvalid", 32'(bus.m0_rvalid), 32'd0);
        check("lk_post_rdata",  32'(bus.m0_rdata),  32'h00);
        check("lk_post_m1_gnt", 32'(bus.m1_gnt),    32'd1);
        tick();
        bus.m1_req = 1'b0;
        #1;
        check("lk_m1_rdata", 32'(bus.m1_rdata), 32'h77);

        // Ten idle cycles: RAM stays disabled, read data holds.
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_ena",      32'(bus.ram_ena),  32'd0);
            check("idle_m0_rdata", 32'(bus.m0_rdata), 32'h00);
            check("idle_m1_rdata", 32'(bus.m1_rdata), 32'h77);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
